// File: rtl/image_stream_loader_pkg.sv
// Shared types and layout helpers for the image stream loader and the convolution-side selector.
package image_stream_loader_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } loader_state_t;

    localparam int unsigned COUNT_WIDTH = 16;

    // Index counter width for an n-element frame (n >= 2).
    function automatic int unsigned calc_iw(input int unsigned n);
        return $clog2(n);
    endfunction

    // Flat element index: channel-major, then row, then column.
    function automatic int unsigned elem_index(
        input int unsigned d,
        input int unsigned row,
        input int unsigned col,
        input int unsigned h,
        input int unsigned w
    );
        return (d * h + row) * w + col;
    endfunction

endpackage

// File: rtl/image_stream_loader_if.sv
// Pixel stream handshake: valid/ready beats framed by s_last.
interface image_stream_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/image_stream_loader.sv
// Assembles a framed pixel stream into a flat D*H*W image vector, holds it until acked,
// and rejects short or long frames.
module image_stream_loader
    import image_stream_loader_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned D          = 1,
    parameter  int unsigned H          = 48,
    parameter  int unsigned W          = 48,
    localparam int unsigned N          = D * H * W,
    localparam int unsigned IW         = calc_iw(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    image_stream_loader_if.slave         s,
    output logic [N*DATA_WIDTH-1:0]      image,
    output logic                         image_valid,
    input  logic                         image_ack,
    output logic                         frame_error,
    output logic [COUNT_WIDTH-1:0]       frames_loaded
);

    loader_state_t   state, state_next;
    logic [IW-1:0]   idx, idx_next;
    logic            error_next;
    logic            count_inc;
    logic            accept;
    logic            load_accept;
    logic            idx_at_end;
    logic [N-1:0]    elem_we;

    // Ready is a pure decode of the state register, held low during reset.
    assign s.s_ready   = !reset && (state != FULL);
    assign accept      = s.s_valid && s.s_ready;
    assign load_accept = accept && (state == LOAD);
    assign idx_at_end  = (idx == IW'(N - 1));

    // State, index, and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOAD;
            idx           <= '0;
            image_valid   <= 1'b0;
            frame_error   <= 1'b0;
            frames_loaded <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            image_valid <= (state_next == FULL);
            frame_error <= error_next;
            if (count_inc) begin
                frames_loaded <= frames_loaded + COUNT_WIDTH'(1);
            end
        end
    end

    // Next-state decode and frame framing checks.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        error_next = 1'b0;
        count_inc  = 1'b0;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    if (idx_at_end) begin
                        idx_next = '0;
                        if (s.s_last) begin
                            state_next = FULL;
                            count_inc  = 1'b1;
                        end else begin
                            state_next = DISCARD;
                            error_next = 1'b1;
                        end
                    end else if (s.s_last) begin
                        idx_next   = '0;
                        error_next = 1'b1;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            FULL: begin
                if (image_ack) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            DISCARD: begin
                if (accept && s.s_last) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
                idx_next   = '0;
            end
        endcase
    end

    // One-hot element write enables decoded from the index.
    always_comb begin
        elem_we = '0;
        for (int k = 0; k < int'(N); k++) begin
            elem_we[k] = load_accept && (idx == IW'(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            image <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                if (elem_we[k]) begin
                    image[k*DATA_WIDTH +: DATA_WIDTH] <= s.s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader with a 1x3x3 frame of 8-bit pixels.
module tb_image_stream_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] image;
    logic            image_valid;
    logic            image_ack = 1'b0;
    logic            frame_error;
    logic [15:0]     frames_loaded;

    int total = 0;
    int bad   = 0;
    int err_pulses = 0;
    int err_base;

    image_stream_loader_if #(.DATA_WIDTH(DW)) sif ();

    image_stream_loader #(
        .DATA_WIDTH(DW), .D(1), .H(3), .W(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s             (sif.slave),
        .image         (image),
        .image_valid   (image_valid),
        .image_ack     (image_ack),
        .frame_error   (frame_error),
        .frames_loaded (frames_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error) err_pulses++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and return #1 after the edge that accepts it.
    task automatic send_beat(input logic [DW-1:0] data, input logic last);
        int budget;
        sif.s_valid = 1'b1;
        sif.s_data  = data;
        sif.s_last  = last;
        budget = 0;
        while (!sif.s_ready && budget < 100) begin
            tick();
            budget++;
        end
        if (!sif.s_ready) begin
            check("ready_timeout", 0, 1);
        end else begin
            tick();
        end
    endtask

    task automatic idle();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    // Send count beats base, base+1, ...; s_last on the final one; optional random gaps.
    task automatic send_frame(input logic [DW-1:0] base, input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 3));
                idle();
                for (int j = 0; j < g; j++) tick();
            end
            send_beat(DW'(base + DW'(i)), (i == count - 1));
        end
        idle();
    endtask

    task automatic ack_pulse();
        image_ack = 1'b1;
        tick();
        image_ack = 1'b0;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;

        // 1: reset state then a clean frame with no ack
        tick();
        tick();
        check("rst_ready", sif.s_ready, 0);
        check("rst_valid", image_valid, 0);
        check("rst_image", image, 0);
        check("rst_count", frames_loaded, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", sif.s_ready, 1);
        send_frame(8'h01, 9, 1'b0);
        check("s1_valid", image_valid, 1);
        check("s1_ready", sif.s_ready, 0);
        check("s1_image", image, 72'h090807060504030201);
        check("s1_count", frames_loaded, 1);
        for (int i = 0; i < 20; i++) tick();
        check("s1_hold_valid", image_valid, 1);
        check("s1_hold_image", image, 72'h090807060504030201);

        // 2: ack, then a frame with gaps
        ack_pulse();
        check("s2_ack_valid", image_valid, 0);
        check("s2_ack_ready", sif.s_ready, 1);
        send_frame(8'h11, 9, 1'b1);
        check("s2_valid", image_valid, 1);
        check("s2_image", image, 72'h191817161514131211);
        check("s2_count", frames_loaded, 2);
        ack_pulse();

        // 3: short frame rejected, then a good frame
        err_base = err_pulses;
        send_frame(8'h21, 5, 1'b0);
        check("s3_err_pulse", frame_error, 1);
        check("s3_valid", image_valid, 0);
        tick();
        check("s3_err_clear", frame_error, 0);
        send_frame(8'h21, 9, 1'b0);
        check("s3_image", image, 72'h292827262524232221);
        check("s3_count", frames_loaded, 3);
        check("s3_err_total", err_pulses - err_base, 1);
        ack_pulse();

        // 4: long frame, error after beat 9, tail dropped
        err_base = err_pulses;
        for (int i = 0; i < 9; i++) send_beat(8'h31 + 8'(i), 1'b0);
        check("s4_err_at9", frame_error, 1);
        check("s4_ready_discard", sif.s_ready, 1);
        for (int i = 9; i < 12; i++) send_beat(8'h31 + 8'(i), (i == 11));
        idle();
        check("s4_err_clear", frame_error, 0);
        check("s4_valid", image_valid, 0);
        check("s4_image_tail_dropped", image, 72'h393837363534333231);
        send_frame(8'h41, 9, 1'b0);
        check("s4_good_image", image, 72'h494847464544434241);
        check("s4_count", frames_loaded, 4);
        check("s4_err_total", err_pulses - err_base, 1);
        ack_pulse();

        // 5: reset mid-frame, then a full frame from k=0
        for (int i = 0; i < 4; i++) send_beat(8'h51 + 8'(i), 1'b0);
        idle();
        reset = 1'b1;
        #1;
        check("s5_rst_ready", sif.s_ready, 0);
        check("s5_rst_image", image, 0);
        check("s5_rst_valid", image_valid, 0);
        check("s5_rst_err", frame_error, 0);
        check("s5_rst_count", frames_loaded, 0);
        tick();
        reset = 1'b0;
        #1;
        err_base = err_pulses;
        send_frame(8'h61, 9, 1'b0);
        check("s5_image", image, 72'h696867666564636261);
        check("s5_count", frames_loaded, 1);
        check("s5_err_total", err_pulses - err_base, 0);
        ack_pulse();

        // 6: ack held high the whole time
        image_ack = 1'b1;
        send_frame(8'h71, 9, 1'b0);
        check("s6_full_valid", image_valid, 1);
        check("s6_full_ready", sif.s_ready, 0);
        check("s6_image", image, 72'h797877767574737271);
        tick();
        check("s6_after_valid", image_valid, 0);
        check("s6_after_ready", sif.s_ready, 1);
        check("s6_count", frames_loaded, 2);
        image_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_stream_loader.md
# image_stream_loader

Loads one image into the flat `image` vector consumed by the convolution layer. Pixels arrive one beat at a time over a valid/ready stream framed by `s_last`. The block assembles the beats into the D×H×W vector and holds it stable with `image_valid` until the consumer acknowledges it. Malformed frames (short or long) are rejected and never presented downstream.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per pixel/element
- D, 1, image depth (channels)
- H, 48, image height
- W, 48, image width
- N (localparam), D*H*W, elements per frame; must be ≥ 2
- IW (localparam), $clog2(N), index counter width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- s_data  in  DATA_WIDTH  pixel value
- s_valid  in  1  beat offered
- s_ready  out  1  block can accept a beat
- s_last  in  1  final beat of frame
- image  out  N*DATA_WIDTH  assembled image; element k at image[k*DATA_WIDTH +: DATA_WIDTH]
- image_valid  out  1  image complete and stable
- image_ack  in  1  consumer has taken the image
- frame_error  out  1  one-cycle pulse on rejected frame
- frames_loaded  out  16  count of good frames, wraps at 2^16

## Operation
- Element order is channel-major, then row, then column: k = (d*H + row)*W + col. The first beat is k=0.
- A beat is accepted when s_valid && s_ready at a rising edge. The accepted beat writes s_data to element idx, then idx increments.
- States:
  - LOAD: s_ready=1, image_valid=0.
    - Accept with idx==N-1 and s_last=1: go to FULL, frames_loaded+1, idx←0.
    - Accept with idx<N-1 and s_last=1 (short frame): frame_error pulse, idx←0, stay in LOAD.
    - Accept with idx==N-1 and s_last=0 (long frame): frame_error pulse, go to DISCARD, idx←0.
  - FULL: s_ready=0, image_valid=1, image frozen.
    - image_ack=1 at an edge: go to LOAD, idx←0.
  - DISCARD: s_ready=1. Accepted beats are dropped and image is not written.
    - Accept with s_last=1: go to LOAD.
- Short and long frames leave partially overwritten data in `image`. That data is never flagged valid.
- image_ack outside FULL is ignored.
- s_valid is not required to stay high between beats. Gaps of any length are allowed.
- s_ready is a combinational decode of the state register only and does not depend on s_valid.

## Timing
- Reset, asynchronous and applied immediately:
  - state=LOAD, idx=0, image=0, image_valid=0, frame_error=0, frames_loaded=0.
  - s_ready is forced to 0 while reset is high and becomes 1 in the first cycle after deassertion.
- Throughput: one beat per cycle in LOAD and DISCARD.
- Latency: when the last good beat is accepted at edge t, image_valid=1 and image is complete from t until the ack edge.
- Ack: when image_ack is sampled at edge t in FULL, image_valid=0 and s_ready=1 after t. The next frame's first beat can be accepted at edge t+1.
- frame_error is a registered pulse, high for exactly the one cycle following the offending accept.
- Reset mid-frame or in FULL discards everything. The next beat after reset is treated as k=0.

## Structure
- Shared package holds:
  - the state enum {LOAD, FULL, DISCARD}
  - a helper function computing IW
  - the element-index formula, shared with the convolution-side selector so both agree on layout
- No sub-module is required. The write path is a decoded per-element enable: element k is enabled when idx==k and the beat is accepted in LOAD.

## Test plan
Bench parameters: DATA_WIDTH=8, D=1, H=3, W=3, N=9.
1. Reset, then 9 beats of values 1..9 with s_last on beat 9, then no ack.
   - image_valid=1 and s_ready=0 one cycle after the last accept.
   - image = 0x090807060504030201.
   - frames_loaded=1; the image stays stable for 20 cycles.
2. Pulse image_ack after scenario 1, then send beats 0x11..0x19 with random s_valid gaps.
   - s_ready returns 1 on the cycle after the ack.
   - The second image holds 0x19..0x11.
   - frames_loaded=2.
3. Short frame: 5 beats, s_last on beat 5, then a good 9-beat frame.
   - One frame_error pulse; image_valid stays 0.
   - The good frame then loads correctly.
4. Long frame: 12 beats, s_last on beat 12.
   - frame_error one cycle after beat 9.
   - Beats 10–12 accepted and dropped.
   - A following good frame loads at k=0.
5. Assert reset after 4 beats, then send a full frame.
   - All outputs are 0 during reset.
   - The new frame loads from k=0 with no frame_error.
6. Hold image_ack=1 throughout.
   - Ack is ignored in LOAD.
   - FULL lasts exactly one cycle; s_ready drops for that single cycle.
